// File: rtl/cdp1802_io_pkg.sv
// rtl/cdp1802_io_pkg.sv - shared constants and state types for the cdp1802 uart port
// Purpose: default I/O port numbers, status byte bit positions, tx/rx FSM states,
//          and the status byte packing helper.
package cdp1802_io_pkg;

   localparam logic [2:0] IO_DATA_PORT = 3'd1;
   localparam logic [2:0] IO_STAT_PORT = 3'd2;

   localparam int ST_RX_READY   = 0;
   localparam int ST_TX_FULL    = 1;
   localparam int ST_TX_IDLE    = 2;
   localparam int ST_RX_OVERRUN = 3;
   localparam int ST_FRAME_ERR  = 4;
   localparam int ST_TX_OVERRUN = 5;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_e;

   // RX_WAIT_HIGH holds off edge detection after a bad stop bit until the line recovers.
   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_HIGH
   } rx_state_e;

   function automatic logic [7:0] make_status(
      input logic rx_ready,
      input logic tx_full,
      input logic tx_idle,
      input logic rx_overrun,
      input logic frame_err,
      input logic tx_overrun
   );
      logic [7:0] s;
      s                = 8'h00;
      s[ST_RX_READY]   = rx_ready;
      s[ST_TX_FULL]    = tx_full;
      s[ST_TX_IDLE]    = tx_idle;
      s[ST_RX_OVERRUN] = rx_overrun;
      s[ST_FRAME_ERR]  = frame_err;
      s[ST_TX_OVERRUN] = tx_overrun;
      return s;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous byte FIFO feeding the uart transmitter
// Purpose: DEPTH-entry FIFO (DEPTH power of two, >= 2) with first-word fall-through read.
// Ports:
//   clock, resetq       clock and synchronous active-low reset
//   push, wdata         write request and data; accepted when not full or when popping
//   pop                 read request; rdata is the head entry while not empty
//   rdata               head of queue
//   full, empty         occupancy flags
module uart_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             resetq,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == (AW+1)'(DEPTH));
   assign rdata   = mem_q[rd_ptr_q];

   // A push on a full FIFO still lands if the head leaves in the same cycle.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetq) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/cdp1802_uart_port.sv
// rtl/cdp1802_uart_port.sv - cdp1802 I/O-bus responder with 8N1 uart
// Purpose: OUT DATA_PORT queues a tx byte, INP DATA_PORT reads rx data,
//          INP STAT_PORT reads status, OUT STAT_PORT writes control (bit0 loopback).
// Ports:
//   clock, resetq                  clock and synchronous active-low reset
//   io_n, io_inp, io_out, io_dout  core I/O bus request
//   io_din                         read data to core (0 unless a matching INP)
//   ef                             {0, 0, tx_full, rx_ready} to core EF inputs
//   rxd, txd                       serial lines, idle high
module cdp1802_uart_port
   import cdp1802_io_pkg::*;
#(
   parameter int         CLKS_PER_BIT = 16,
   parameter int         TX_DEPTH     = 4,
   parameter logic [2:0] DATA_PORT    = IO_DATA_PORT,
   parameter logic [2:0] STAT_PORT    = IO_STAT_PORT
) (
   input  logic       clock,
   input  logic       resetq,
   input  logic [2:0] io_n,
   input  logic       io_inp,
   input  logic       io_out,
   input  logic [7:0] io_dout,
   output logic [7:0] io_din,
   output logic [3:0] ef,
   input  logic       rxd,
   output logic       txd
);

   localparam int            BW        = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);

   // bus decode
   logic wr_data, wr_ctrl, rd_data, rd_stat;
   assign wr_data = io_out && (io_n == DATA_PORT);
   assign wr_ctrl = io_out && (io_n == STAT_PORT);
   assign rd_data = io_inp && (io_n == DATA_PORT);
   assign rd_stat = io_inp && (io_n == STAT_PORT);

   // tx fifo
   logic       fifo_pop, fifo_full, fifo_empty;
   logic [7:0] fifo_rdata;

   uart_tx_fifo #(
      .DEPTH (TX_DEPTH),
      .WIDTH (8)
   ) u_tx_fifo (
      .clock  (clock),
      .resetq (resetq),
      .push   (wr_data),
      .pop    (fifo_pop),
      .wdata  (io_dout),
      .rdata  (fifo_rdata),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   // tx serializer
   tx_state_e     tx_state_q, tx_state_d;
   logic [BW-1:0] tx_baud_q, tx_baud_d;
   logic [2:0]    tx_bit_q, tx_bit_d;
   logic [7:0]    tx_shift_q, tx_shift_d;

   always_comb begin
      tx_state_d = tx_state_q;
      tx_baud_d  = tx_baud_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      fifo_pop   = 1'b0;
      case (tx_state_q)
         TX_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               tx_shift_d = fifo_rdata;
               tx_baud_d  = '0;
               tx_state_d = TX_START;
            end
         end
         TX_START: begin
            if (tx_baud_q == BAUD_LAST) begin
               tx_baud_d  = '0;
               tx_bit_d   = 3'd0;
               tx_state_d = TX_DATA;
            end else begin
               tx_baud_d = tx_baud_q + BW'(1);
            end
         end
         TX_DATA: begin
            if (tx_baud_q == BAUD_LAST) begin
               tx_baud_d  = '0;
               tx_shift_d = {1'b0, tx_shift_q[7:1]};
               if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
               else                  tx_bit_d   = tx_bit_q + 3'd1;
            end else begin
               tx_baud_d = tx_baud_q + BW'(1);
            end
         end
         TX_STOP: begin
            if (tx_baud_q == BAUD_LAST) begin
               tx_baud_d = '0;
               // Chain straight into the next start bit so queued bytes leave gap-free.
               if (!fifo_empty) begin
                  fifo_pop   = 1'b1;
                  tx_shift_d = fifo_rdata;
                  tx_state_d = TX_START;
               end else begin
                  tx_state_d = TX_IDLE;
               end
            end else begin
               tx_baud_d = tx_baud_q + BW'(1);
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   always_comb begin
      case (tx_state_q)
         TX_START: txd = 1'b0;
         TX_DATA:  txd = tx_shift_q[0];
         default:  txd = 1'b1;
      endcase
   end

   // rx synchronizer and edge detect
   logic loopback_q, loopback_d;
   logic rx_sync1_q, rx_sync2_q, rx_prev_q;
   logic rx_in, rx_fall;

   assign rx_in   = loopback_q ? txd : rxd;
   assign rx_fall = rx_prev_q && !rx_sync2_q;

   // rx deserializer
   rx_state_e     rx_state_q, rx_state_d;
   logic [BW-1:0] rx_baud_q, rx_baud_d;
   logic [2:0]    rx_bit_q, rx_bit_d;
   logic [7:0]    rx_shift_q, rx_shift_d;
   logic          rx_done, rx_ferr;

   always_comb begin
      rx_state_d = rx_state_q;
      rx_baud_d  = rx_baud_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_done    = 1'b0;
      rx_ferr    = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (rx_fall) begin
               rx_baud_d  = '0;
               rx_state_d = RX_START;
            end
         end
         RX_START: begin
            // Mid start bit: a high line here means the falling edge was noise.
            if (rx_baud_q == HALF_LAST) begin
               rx_baud_d = '0;
               if (rx_sync2_q) begin
                  rx_state_d = RX_IDLE;
               end else begin
                  rx_bit_d   = 3'd0;
                  rx_state_d = RX_DATA;
               end
            end else begin
               rx_baud_d = rx_baud_q + BW'(1);
            end
         end
         RX_DATA: begin
            if (rx_baud_q == BAUD_LAST) begin
               rx_baud_d  = '0;
               rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
               if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
               else                  rx_bit_d   = rx_bit_q + 3'd1;
            end else begin
               rx_baud_d = rx_baud_q + BW'(1);
            end
         end
         RX_STOP: begin
            if (rx_baud_q == BAUD_LAST) begin
               rx_baud_d = '0;
               if (rx_sync2_q) begin
                  rx_done    = 1'b1;
                  rx_state_d = RX_IDLE;
               end else begin
                  rx_ferr    = 1'b1;
                  rx_state_d = RX_WAIT_HIGH;
               end
            end else begin
               rx_baud_d = rx_baud_q + BW'(1);
            end
         end
         RX_WAIT_HIGH: begin
            if (rx_sync2_q) rx_state_d = RX_IDLE;
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // rx holding register and sticky flags
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_ready_q, rx_ready_d;
   logic       rx_ovr_q, rx_ovr_d;
   logic       ferr_q, ferr_d;
   logic       tx_ovr_q, tx_ovr_d;
   logic       rx_ovr_set, tx_ovr_set;

   always_comb begin
      rx_data_d  = rx_data_q;
      rx_ready_d = rx_ready_q;
      rx_ovr_set = 1'b0;
      if (rx_done) begin
         // A read in the same cycle frees the holder, so the new byte is kept.
         if (!rx_ready_q || rd_data) begin
            rx_data_d  = rx_shift_q;
            rx_ready_d = 1'b1;
         end else begin
            rx_ovr_set = 1'b1;
         end
      end else if (rd_data) begin
         rx_ready_d = 1'b0;
      end
   end

   assign tx_ovr_set = wr_data && fifo_full && !fifo_pop;

   // Status read clears the sticky bits, but an event landing on the same edge survives.
   assign rx_ovr_d   = rx_ovr_set || (rx_ovr_q && !rd_stat);
   assign ferr_d     = rx_ferr    || (ferr_q   && !rd_stat);
   assign tx_ovr_d   = tx_ovr_set || (tx_ovr_q && !rd_stat);
   assign loopback_d = wr_ctrl ? io_dout[0] : loopback_q;

   always_ff @(posedge clock) begin
      if (!resetq) begin
         tx_state_q <= TX_IDLE;
         tx_baud_q  <= '0;
         tx_bit_q   <= 3'd0;
         tx_shift_q <= 8'h00;
         rx_state_q <= RX_IDLE;
         rx_baud_q  <= '0;
         rx_bit_q   <= 3'd0;
         rx_shift_q <= 8'h00;
         rx_sync1_q <= 1'b1;
         rx_sync2_q <= 1'b1;
         rx_prev_q  <= 1'b1;
         rx_data_q  <= 8'h00;
         rx_ready_q <= 1'b0;
         rx_ovr_q   <= 1'b0;
         ferr_q     <= 1'b0;
         tx_ovr_q   <= 1'b0;
         loopback_q <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_baud_q  <= tx_baud_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         rx_state_q <= rx_state_d;
         rx_baud_q  <= rx_baud_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_sync1_q <= rx_in;
         rx_sync2_q <= rx_sync1_q;
         rx_prev_q  <= rx_sync2_q;
         rx_data_q  <= rx_data_d;
         rx_ready_q <= rx_ready_d;
         rx_ovr_q   <= rx_ovr_d;
         ferr_q     <= ferr_d;
         tx_ovr_q   <= tx_ovr_d;
         loopback_q <= loopback_d;
      end
   end

   // bus read side
   logic [7:0] status;
   assign status = make_status(rx_ready_q, fifo_full,
                               fifo_empty && (tx_state_q == TX_IDLE),
                               rx_ovr_q, ferr_q, tx_ovr_q);

   always_comb begin
      io_din = 8'h00;
      if (rd_data)      io_din = rx_data_q;
      else if (rd_stat) io_din = status;
   end

   assign ef = {2'b00, fifo_full, rx_ready_q};

endmodule

// File: tb/tb_cdp1802_uart_port.sv
// tb/tb_cdp1802_uart_port.sv - directed self-checking bench for cdp1802_uart_port
module tb_cdp1802_uart_port;

   logic       clock   = 1'b0;
   logic       resetq  = 1'b0;
   logic [2:0] io_n    = 3'd0;
   logic       io_inp  = 1'b0;
   logic       io_out  = 1'b0;
   logic [7:0] io_dout = 8'h00;
   logic       rxd     = 1'b1;
   wire  [7:0] io_din;
   wire  [3:0] ef;
   wire        txd;

   int checks   = 0;
   int failures = 0;

   logic [255:0] hist = '0;
   logic [199:0] exp_bits;
   logic [7:0]   rd;
   logic         found;
   int           lat;

   always #5 clock = ~clock;

   // txd history, one sample per falling edge, newest in bit 0
   always @(negedge clock) hist <= {hist[254:0], txd};

   cdp1802_uart_port #(
      .CLKS_PER_BIT (4),
      .TX_DEPTH     (4),
      .DATA_PORT    (3'd1),
      .STAT_PORT    (3'd2)
   ) dut (
      .clock   (clock),
      .resetq  (resetq),
      .io_n    (io_n),
      .io_inp  (io_inp),
      .io_out  (io_out),
      .io_dout (io_dout),
      .io_din  (io_din),
      .ef      (ef),
      .rxd     (rxd),
      .txd     (txd)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_wide(input string tag, input logic [199:0] obs, input logic [199:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // bus tasks start and end on a falling edge
   task automatic out_wr(input logic [2:0] port, input logic [7:0] d);
      io_out  = 1'b1;
      io_n    = port;
      io_dout = d;
      @(negedge clock);
      io_out  = 1'b0;
   endtask

   task automatic inp_rd(input logic [2:0] port, output logic [7:0] d);
      io_inp = 1'b1;
      io_n   = port;
      #1 d   = io_din;
      @(negedge clock);
      io_inp = 1'b0;
   endtask

   task automatic rx_send(input logic [7:0] b, input logic stop_bit);
      rxd = 1'b0;
      repeat (4) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (4) @(negedge clock);
      end
      rxd = stop_bit;
      repeat (4) @(negedge clock);
      rxd = 1'b1;
   endtask

   function automatic logic frame_bit(input logic [7:0] b, input int i);
      if (i < 4)  return 1'b0;
      if (i < 36) return b[(i - 4) / 4];
      return 1'b1;
   endfunction

   initial begin
      // reset, then reset again in the middle of a frame
      repeat (3) @(negedge clock);
      resetq = 1'b1;
      @(negedge clock);
      out_wr(3'd1, 8'h00);
      repeat (8) @(negedge clock);
      resetq = 1'b0;
      repeat (2) @(negedge clock);
      chk("reset_txd", {31'd0, txd}, 32'd1);
      chk("reset_ef", {28'd0, ef}, 32'h0);
      chk("reset_io_din", {24'd0, io_din}, 32'h00);
      resetq = 1'b1;
      inp_rd(3'd2, rd);
      chk("reset_status", {24'd0, rd}, 32'h04);

      // single byte 0x7B frame shape
      out_wr(3'd1, 8'h7B);
      repeat (41) @(negedge clock);
      exp_bits = '0;
      for (int i = 0; i < 40; i++) exp_bits = {exp_bits[198:0], frame_bit(8'h7B, i)};
      chk_wide("tx_7b_frame", {160'd0, hist[39:0]}, exp_bits);
      inp_rd(3'd2, rd);
      chk("tx_7b_idle", {24'd0, rd}, 32'h04);

      // burst of five, then an overrunning sixth
      for (int b = 1; b <= 5; b++) out_wr(3'd1, 8'(b));
      chk("burst_ef_full", {28'd0, ef}, 32'h2);
      out_wr(3'd1, 8'h06);
      inp_rd(3'd2, rd);
      chk("burst_tx_overrun", {24'd0, rd}, 32'h22);
      inp_rd(3'd2, rd);
      chk("burst_overrun_cleared", {24'd0, rd}, 32'h02);
      repeat (194) @(negedge clock);
      exp_bits = '0;
      for (int b = 1; b <= 5; b++)
         for (int i = 0; i < 40; i++) exp_bits = {exp_bits[198:0], frame_bit(8'(b), i)};
      chk_wide("burst_five_frames", hist[199:0], exp_bits);
      inp_rd(3'd2, rd);
      chk("burst_drained", {24'd0, rd}, 32'h04);

      // loopback
      out_wr(3'd2, 8'h01);
      out_wr(3'd1, 8'hA5);
      found = 1'b0;
      lat   = 0;
      for (int i = 1; i <= 80 && !found; i++) begin
         @(negedge clock);
         if (ef[0]) begin
            found = 1'b1;
            lat   = i;
         end
      end
      chk("loop_rx_ready", {31'd0, found}, 32'd1);
      chk("loop_latency", {31'd0, (lat >= 38 && lat <= 46)}, 32'd1);
      inp_rd(3'd1, rd);
      chk("loop_data", {24'd0, rd}, 32'hA5);
      chk("loop_ready_cleared", {31'd0, ef[0]}, 32'd0);
      out_wr(3'd2, 8'h00);
      repeat (4) @(negedge clock);
      inp_rd(3'd2, rd);
      chk("loop_status", {24'd0, rd}, 32'h04);

      // framing error
      rx_send(8'h3C, 1'b0);
      repeat (8) @(negedge clock);
      chk("ferr_ef", {28'd0, ef}, 32'h0);
      inp_rd(3'd2, rd);
      chk("ferr_status", {24'd0, rd}, 32'h14);

      // two bytes without a read
      rx_send(8'h11, 1'b1);
      rx_send(8'h22, 1'b1);
      repeat (8) @(negedge clock);
      chk("ovr_ef", {28'd0, ef}, 32'h1);
      inp_rd(3'd1, rd);
      chk("ovr_data", {24'd0, rd}, 32'h11);
      inp_rd(3'd2, rd);
      chk("ovr_status", {24'd0, rd}, 32'h0C);

      // one-clock glitch on rxd
      rxd = 1'b0;
      @(negedge clock);
      rxd = 1'b1;
      repeat (10) @(negedge clock);
      chk("glitch_ef", {28'd0, ef}, 32'h0);
      inp_rd(3'd2, rd);
      chk("glitch_status", {24'd0, rd}, 32'h04);
      inp_rd(3'd1, rd);
      chk("stale_data", {24'd0, rd}, 32'h11);
      inp_rd(3'd5, rd);
      chk("unmatched_port", {24'd0, rd}, 32'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cdp1802_uart_port.md
Name: cdp1802_uart_port

Overview:
- I/O-bus responder for the cdp1802 core: the peripheral end of its io_n / io_inp / io_out / io_din / io_dout interface.
- OUT to the data port queues a byte for 8N1 serial transmission. INP reads received data or a status byte.
- Ready/full flags are also driven onto the core's EF inputs, so firmware can poll with B1/B2 branches.
- Instantiated beside the core and RAM at SoC top level.

Parameters:
- CLKS_PER_BIT, 16, clocks per serial bit (>=4).
- TX_DEPTH, 4, TX FIFO entries (power of two).
- DATA_PORT, 3'd1, io_n value for OUT (tx write) and INP (rx read).
- STAT_PORT, 3'd2, io_n value for INP status read; OUT writes the control register.

Ports:
- clock  in  1  single system clock, all logic on rising edge.
- resetq  in  1  synchronous active-low reset, sampled on rising edge of clock.
- io_n  in  3  port number from core, valid while io_inp/io_out high.
- io_inp  in  1  one-cycle INP strobe.
- io_out  in  1  one-cycle OUT strobe.
- io_dout  in  8  data from core on OUT.
- io_din  out  8  data to core on INP.
- ef  out  4  to core EF: ef[0]=rx_ready, ef[1]=tx_full, ef[3:2]=0.
- rxd  in  1  serial in, asynchronous, idle high.
- txd  out  1  serial out, idle high.

Behaviour:
- Reset (resetq=0 at an edge):
  - txd=1, io_din=0, ef=0.
  - FIFO empty, rx holding empty, all sticky flags clear, control=0.
  - Takes effect mid-frame: the frame in progress is abandoned, txd returns to 1 next cycle.
- io_din:
  - Combinational. Equals the selected register while io_inp=1 and io_n matches DATA_PORT or STAT_PORT; otherwise 8'h00.
  - Side effects (pop/clear) occur at the edge ending the strobe cycle.
- Status byte:
  - b0 rx_ready, b1 tx_full, b2 tx_idle (FIFO empty and shifter idle), b3 rx_overrun, b4 frame_err, b5 tx_overrun, b7:6=0.
  - INP STAT_PORT clears b3–b5 at that edge. A sticky event in the same cycle wins (stays set).
- Control register:
  - OUT STAT_PORT writes control[0]=loopback. When set, the rx input is txd instead of the rxd pin.
- TX FIFO:
  - OUT DATA_PORT pushes io_dout.
  - Push when full: data discarded, tx_overrun set.
  - Push and shifter pop in the same cycle on a full FIFO: both occur, byte accepted.
- TX serializer:
  - States IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE. Each state lasts CLKS_PER_BIT clocks.
  - Pops the FIFO on the cycle IDLE sees non-empty; txd goes 0 the next cycle.
  - Back-to-back bytes: STOP goes directly to START if the FIFO is non-empty, with no idle gap.
- RX:
  - rxd passes through a 2-flop synchronizer (2 cycles latency).
  - States IDLE -> START -> DATA -> STOP.
  - IDLE: a falling edge starts the half-bit counter.
  - START: rx re-sampled at CLKS_PER_BIT/2. If high, it was a glitch; return to IDLE.
  - DATA: sample every CLKS_PER_BIT at mid-bit, 8 bits LSB first.
  - STOP: sampled at mid-bit.
    - Stop=1: byte to holding register, rx_ready=1.
    - Stop=0: frame_err set, byte discarded, wait for rx high before IDLE.
  - Byte completes while rx_ready=1 and not being read: new byte discarded, rx_overrun set.
  - Byte completes in the same cycle as INP DATA_PORT: the old byte is returned on io_din, the new byte is loaded, rx_ready stays 1.
  - INP DATA_PORT with rx_ready=0: returns the last held byte, no flag change.
- Unmatched io_n values and OUT to unmatched ports are ignored.
- Counters: bit counter 3 bits, baud counter clog2(CLKS_PER_BIT) bits. Wrap-around is not permitted; reload on every state change.

Decomposition:
- Package cdp1802_io_pkg:
  - port-number constants;
  - status bit index constants;
  - tx/rx state enums.
- One natural sub-module: uart_tx_fifo, a synchronous FIFO with push/pop/full/empty and same-cycle push+pop on full.
- RX and TX FSMs stay in the top module.

Test Plan:
- CLKS_PER_BIT=4 for all scenarios.
- Reset: hold resetq=0 for 2 edges mid-transmission -> txd=1, ef=4'b0000, INP 2 returns 8'h04.
- OUT 1 with 8'h7B -> txd low 4 clocks, bits 1,1,0,1,1,1,1,0 at 4 clocks each, high 4 clocks. Frame = 40 clocks; tx_idle=1 afterwards.
- OUT 1 five times (8'h01..8'h05) back-to-back with no drain -> FIFO full after the first pop.
  - ef[1]=1, no byte lost; five contiguous frames, no gap.
  - A 6th write while full -> tx_overrun=1 (INP 2 bit5), then cleared by that read.
- Loopback: OUT 2 with 8'h01, then OUT 1 with 8'hA5.
  - ~42 clocks later ef[0]=1; INP 1 returns 8'hA5; ef[0]=0 next cycle.
- Drive rxd with a frame 8'h3C having stop bit=0 -> frame_err=1, rx_ready=0.
- Drive two frames (8'h11, 8'h22) without reading -> INP 1 = 8'h11, rx_overrun=1.
- Drive rxd low for 1 clock -> no reception, status unchanged.
